// File: rtl/data_inf_interconnect_s2m_addr.sv
// One-to-NUM valid/ready router steered by s_addr; index >= NUM is dropped (optional drop counter: DATA_INF_S2M_ERR_CNT_EN).
// Latency: 1 cycle from accept to m_valid, sustaining 1 word/cycle with output reg + skid reg.
// Backpressure: registered s_ready = !skid_full; a stalled destination blocks all ports (head-of-line).
module data_inf_interconnect_s2m_addr #(
    parameter int NUM   = 8,
    parameter int NSIZE = $clog2(NUM),
    parameter int DSIZE = 32
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             s_valid,
    input  logic [DSIZE-1:0] s_data,
    input  logic [NSIZE-1:0] s_addr,
    output logic             s_ready,
    output logic [NUM-1:0]   m_valid,
    output logic [DSIZE-1:0] m_data,
    input  logic [NUM-1:0]   m_ready,
    output logic [NSIZE-1:0] curr_path
`ifdef DATA_INF_S2M_ERR_CNT_EN
    ,
    output logic [15:0]      err_cnt
`endif
);

    logic             r_ovld;
    logic [DSIZE-1:0] r_odata;
    logic [NSIZE-1:0] r_oaddr;
    logic             r_kvld;
    logic [DSIZE-1:0] r_kdata;
    logic [NSIZE-1:0] r_kaddr;
    logic             r_s_ready;

    logic w_sel_rdy;
    logic w_ofree;
    logic w_sfire;
    logic w_route;
    logic w_take;
    logic w_kvld_nxt;

    // Only reachable when NUM is not a power of two; avoids a constant compare otherwise.
    generate
        if (NUM == (1 << NSIZE)) begin : g_pow2
            assign w_route = 1'b1;
        end else begin : g_npow2
            localparam logic [NSIZE:0] LP_NUM = (NSIZE + 1)'(NUM);
            assign w_route = ({1'b0, s_addr} < LP_NUM);
        end
    endgenerate

    assign w_sel_rdy  = m_ready[r_oaddr];
    assign w_ofree    = !r_ovld || w_sel_rdy;
    assign w_sfire    = s_valid && r_s_ready;
    assign w_take     = w_sfire && w_route;
    // Skid can only fill while the output is held; when the output frees, the skid always drains.
    assign w_kvld_nxt = w_ofree ? 1'b0 : (r_kvld || w_take);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_ovld    <= 1'b0;
            r_odata   <= '0;
            r_oaddr   <= '0;
            r_kvld    <= 1'b0;
            r_kdata   <= '0;
            r_kaddr   <= '0;
            r_s_ready <= 1'b0;
        end else begin
            r_s_ready <= !w_kvld_nxt;
            r_kvld    <= w_kvld_nxt;
            if (w_ofree) begin
                if (r_kvld) begin
                    r_ovld  <= 1'b1;
                    r_odata <= r_kdata;
                    r_oaddr <= r_kaddr;
                end else if (w_take) begin
                    r_ovld  <= 1'b1;
                    r_odata <= s_data;
                    r_oaddr <= s_addr;
                end else begin
                    r_ovld  <= 1'b0;
                end
            end else if (w_take) begin
                r_kdata <= s_data;
                r_kaddr <= s_addr;
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM; k++) begin : g_mvld
            assign m_valid[k] = r_ovld && (r_oaddr == NSIZE'(k));
        end
    endgenerate

    assign m_data    = r_odata;
    assign curr_path = r_oaddr;
    assign s_ready   = r_s_ready;

`ifdef DATA_INF_S2M_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_sfire && !w_route && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_data_inf_interconnect_s2m_addr.sv
// Bench for data_inf_interconnect_s2m_addr with NUM=6 so indices 6 and 7 exercise the drop path.
// Accepted routable words are queued by the driver; a negedge monitor pops and compares on each transfer.
module tb_data_inf_interconnect_s2m_addr;

    localparam int NUM   = 6;
    localparam int NSIZE = 3;
    localparam int DSIZE = 32;

    logic             clock;
    logic             rst_n;
    logic             s_valid;
    logic [DSIZE-1:0] s_data;
    logic [NSIZE-1:0] s_addr;
    logic             s_ready;
    logic [NUM-1:0]   m_valid;
    logic [DSIZE-1:0] m_data;
    logic [NUM-1:0]   m_ready;
    logic [NSIZE-1:0] curr_path;
`ifdef DATA_INF_S2M_ERR_CNT_EN
    logic [15:0]      err_cnt;
`endif

    data_inf_interconnect_s2m_addr #(.NUM(NUM), .NSIZE(NSIZE), .DSIZE(DSIZE)) u_dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_addr    (s_addr),
        .s_ready   (s_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .curr_path (curr_path)
`ifdef DATA_INF_S2M_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    typedef struct packed {
        logic [31:0] d;
        logic [2:0]  a;
        logic [31:0] c;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] cyc = 0;
    bit          lat_chk = 0;
    bit          rnd_run = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: scoreboard pops, one-hot and hold-until-transfer checks.
    bit             prev_hold = 0;
    logic [NUM-1:0] prev_v;
    logic [31:0]    prev_d;
    always @(negedge clock) begin
        if (!rst_n) begin
            prev_hold = 0;
        end else begin
            check("onehot", 64'($countones(m_valid) <= 1), 64'd1);
            if (prev_hold) begin
                check("hold_valid", 64'(m_valid), 64'(prev_v));
                check("hold_data", 64'(m_data), 64'(prev_d));
            end
            for (int k = 0; k < NUM; k++) begin
                if (m_valid[k] && m_ready[k]) begin
                    check("curr_path", 64'(curr_path), 64'(k));
                    if (q.size() == 0) begin
                        check("unexpected_word", 64'(m_data), 64'hDEAD);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        check("sb_data", 64'(m_data), 64'(e.d));
                        check("sb_port", 64'(k), 64'(e.a));
                        if (lat_chk) check("latency", 64'(cyc), 64'(e.c));
                    end
                end
            end
            prev_hold = |(m_valid & ~m_ready);
            prev_v    = m_valid;
            prev_d    = m_data;
        end
    end

    task automatic send(input logic [31:0] d, input logic [2:0] a, output int tries);
        logic rdy;
        s_valid = 1'b1;
        s_data  = d;
        s_addr  = a;
        tries   = 0;
        do begin
            @(negedge clock);
            rdy = s_ready;
            @(posedge clock);
            #1;
            tries++;
        end while (!rdy && tries < 500);
        if (!rdy) check("accept_timeout", 64'(rdy), 64'd1);
        else if (a < NUM) q.push_back({d, a, cyc});
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    int tries;
    int done_rnd;
`ifdef DATA_INF_S2M_ERR_CNT_EN
    logic [15:0] err0;
`endif

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_addr  = '0;
        m_ready = '0;
        #12;
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_curr_path", 64'(curr_path), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
`ifdef DATA_INF_S2M_ERR_CNT_EN
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
`endif
        @(posedge clock);
        #1 rst_n = 1'b1;
        @(negedge clock);
        check("rst_release_s_ready", 64'(s_ready), 64'd0);
        idle(1);
        check("first_clk_s_ready", 64'(s_ready), 64'd1);

        // Back-to-back streaming with all ports ready.
        m_ready = '1;
        lat_chk = 1;
        for (int i = 0; i < 16; i++) begin
            send(32'(i), 3'(i % NUM), tries);
            check("b2b_no_stall", 64'(tries), 64'd1);
        end
        idle(3);
        lat_chk = 0;

        // Head-of-line stall on port 3 with second word parked in skid.
        m_ready = 6'b110111;
        send(32'hA, 3'd3, tries);
        send(32'hB, 3'd5, tries);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("stall_s_ready", 64'(s_ready), 64'd0);
            check("stall_m_valid", 64'(m_valid), 64'h08);
            check("stall_m_data", 64'(m_data), 64'hA);
            check("stall_curr_path", 64'(curr_path), 64'd3);
            @(posedge clock);
            #1;
        end
        m_ready = '1;
        @(negedge clock);
        check("release_A_valid", 64'(m_valid), 64'h08);
        @(negedge clock);
        check("release_B_valid", 64'(m_valid), 64'h20);
        check("release_B_data", 64'(m_data), 64'hB);
        check("release_s_ready", 64'(s_ready), 64'd1);
        @(negedge clock);
        check("release_empty", 64'(m_valid), 64'd0);
        idle(1);

        // Drop words interleaved with port-0 traffic.
`ifdef DATA_INF_S2M_ERR_CNT_EN
        err0 = err_cnt;
`endif
        send(32'h100, 3'd0, tries);
        send(32'h106, 3'd6, tries);
        send(32'h101, 3'd0, tries);
        send(32'h107, 3'd7, tries);
        send(32'h102, 3'd0, tries);
        idle(3);
        check("drop_drained", 64'(q.size()), 64'd0);
`ifdef DATA_INF_S2M_ERR_CNT_EN
        check("drop_err_cnt", 64'(err_cnt - err0), 64'd2);
`endif

        // Reset with both registers full.
        m_ready = '0;
        send(32'h55, 3'd1, tries);
        send(32'h66, 3'd2, tries);
        idle(1);
        rst_n = 1'b0;
        #1;
        check("midrst_m_valid", 64'(m_valid), 64'd0);
        check("midrst_s_ready", 64'(s_ready), 64'd0);
        check("midrst_m_data", 64'(m_data), 64'd0);
        q.delete();
        @(posedge clock);
        #1 rst_n = 1'b1;
        m_ready = '1;
        @(posedge clock);
        @(negedge clock);
        check("postrst_s_ready", 64'(s_ready), 64'd1);
        check("postrst_m_valid", 64'(m_valid), 64'd0);
        idle(4);

        // Random traffic with random readiness.
        rnd_run = 1;
        fork
            begin
                while (rnd_run) begin
                    @(posedge clock);
                    #1 m_ready = NUM'($urandom);
                end
            end
            begin
                for (int i = 0; i < 1500; i++) begin
                    if ($urandom_range(1) == 1) idle(1);
                    send(32'h8000_0000 + 32'(i), 3'($urandom_range(7)), tries);
                end
                rnd_run = 0;
            end
        join
        m_ready = '1;
        idle(20);
        check("rnd_drained", 64'(q.size()), 64'd0);

`ifdef DATA_INF_S2M_ERR_CNT_EN
        for (int i = 0; i < 65540; i++) send(32'(i), 3'd7, tries);
        idle(2);
        check("err_cnt_saturate", 64'(err_cnt), 64'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

endmodule
